// File: rtl/baser_pkg.sv
// Constants and types shared by the 10GBASE-R TX gearbox, RX descrambler and frame encoder.
package baser_pkg;
   localparam logic [1:0]  SYNC_DATA     = 2'b01;
   localparam logic [1:0]  SYNC_CTRL     = 2'b10;
   localparam logic [7:0]  BLK_TYPE_IDLE = 8'h1E;
   localparam int          SCR_TAP_A     = 38;
   localparam int          SCR_TAP_B     = 57;
   localparam logic [57:0] SCR_SEED      = 58'h3FF_FFFF_FFFF_FFFF;
   localparam logic [5:0]  SEQ_LAST      = 6'd32;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  hdr;
   } blk66_t;

   localparam blk66_t IDLE_BLK = '{data: {56'h0, BLK_TYPE_IDLE}, hdr: SYNC_CTRL};

   function automatic logic is_bad_hdr(input logic [1:0] h);
      return (h == 2'b00) || (h == 2'b11);
   endfunction
endpackage

// File: rtl/baser_scrambler_64.sv
// Registered 64-bit self-synchronous x^58+x^39+1 scrambler; DESCRAMBLE=1 feeds the
// shift register from the input bits instead, turning it into the RX descrambler.
module baser_scrambler_64
   import baser_pkg::*;
#(
   parameter bit BYPASS     = 1'b0,
   parameter bit DESCRAMBLE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic [63:0] data_i,
   output logic [63:0] data_o
);
   logic [57:0] state_q, state_d;
   logic [63:0] data_q, scr;

   // Bit 0 goes on the line first, so it sees the oldest state.
   always_comb begin
      state_d = state_q;
      scr     = '0;
      for (int i = 0; i < 64; i++) begin
         scr[i]  = data_i[i] ^ state_d[SCR_TAP_A] ^ state_d[SCR_TAP_B];
         state_d = {state_d[56:0], (DESCRAMBLE ? data_i[i] : scr[i])};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCR_SEED;
         data_q  <= '0;
      end else if (en_i) begin
         data_q <= BYPASS ? data_i : scr;
         if (!BYPASS) state_q <= state_d;
      end
   end

   assign data_o = data_q;
endmodule

// File: rtl/baser_tx_gearbox_64.sv
// 10GBASE-R TX back end: slot/idle mux, payload scrambler and 66:64 gearbox producing
// a gap-free 64-bit SERDES stream; 32 blocks in per 33 words out.
module baser_tx_gearbox_64
   import baser_pkg::*;
#(
   parameter int DATA_WIDTH        = 64,
   parameter int HDR_WIDTH         = 2,
   parameter bit SCRAMBLER_DISABLE = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] encoded_tx_data,
   input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
   input  logic                  encoded_tx_valid,
   output logic                  encoded_tx_ready,
   output logic [DATA_WIDTH-1:0] serdes_tx_data,
   output logic                  idle_inserted,
   output logic                  tx_bad_block
);
   logic [5:0]   seq_q, seq_d;
   logic [6:0]   cnt_q, cnt_d;
   logic         slot;
   blk66_t       slot_blk;
   logic [63:0]  scr_data;
   logic         s1_vld_q;
   logic [1:0]   s1_hdr_q;
   logic [6:0]   s1_off_q;
   logic [63:0]  buf_q, ser_q;
   logic [127:0] gb;
   logic         idle_q, bad_q;

   assign slot             = rst && (seq_q != SEQ_LAST);
   assign encoded_tx_ready = slot;

   // cnt tracks buffer fill as seen at slot time; it travels with the block as its offset.
   always_comb begin
      slot_blk = '{data: encoded_tx_data, hdr: encoded_tx_hdr};
      if (!encoded_tx_valid) slot_blk = IDLE_BLK;
      seq_d = (seq_q == SEQ_LAST) ? 6'd0 : seq_q + 6'd1;
      cnt_d = slot ? cnt_q + 7'd2 : cnt_q - 7'd64;
   end

   baser_scrambler_64 #(
      .BYPASS     (SCRAMBLER_DISABLE),
      .DESCRAMBLE (1'b0)
   ) u_scr (
      .clk    (clk),
      .rst_n  (rst),
      .en_i   (slot),
      .data_i (slot_blk.data),
      .data_o (scr_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seq_q    <= '0;
         cnt_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_hdr_q <= '0;
         s1_off_q <= '0;
         idle_q   <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         seq_q    <= seq_d;
         cnt_q    <= cnt_d;
         s1_vld_q <= slot;
         idle_q   <= slot && !encoded_tx_valid;
         bad_q    <= slot && encoded_tx_valid && is_bad_hdr(encoded_tx_hdr);
         if (slot) begin
            s1_hdr_q <= slot_blk.hdr;
            s1_off_q <= cnt_q;
         end
      end
   end

   // Fill never exceeds 62 bits before an append, so 66 more always fit in 128.
   always_comb begin
      gb = {64'h0, buf_q};
      if (s1_vld_q) gb = gb | ({62'h0, scr_data, s1_hdr_q} << s1_off_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_q <= '0;
         ser_q <= '0;
      end else begin
         buf_q <= gb[127:64];
         ser_q <= gb[63:0];
      end
   end

   assign serdes_tx_data = ser_q;
   assign idle_inserted  = idle_q;
   assign tx_bad_block   = bad_q;
endmodule

// File: tb/tb_baser_tx_gearbox_64.sv
// Scoreboard bench: a scrambling and a bypass instance share stimulus; the monitor
// re-frames the line stream into 66-bit blocks, descrambles and compares in order.
module tb_baser_tx_gearbox_64;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] data = '0;
   logic [1:0]  hdr = '0;
   logic        valid = 1'b0;
   logic        rdy_s, rdy_b, idle_s, idle_b, bad_s, bad_b;
   logic [63:0] ser_s, ser_b;

   int          checks = 0, failures = 0;
   int          cyc = 0, phase = 0, idle_cnt = 0;
   bit          mon_en = 1'b0;
   bit          exp_idle [0:4095];
   bit          exp_bad  [0:4095];
   logic [65:0] q_s[$], q_b[$];
   logic [255:0] acc [2];
   int          nb [2];
   logic [57:0] dsc;
   logic [63:0] p0 = 64'h0123456789ABCDEF;

   always #5 clk = ~clk;

   baser_tx_gearbox_64 #(.SCRAMBLER_DISABLE(1'b0)) dut_s (
      .clk(clk), .rst(rst), .encoded_tx_data(data), .encoded_tx_hdr(hdr),
      .encoded_tx_valid(valid), .encoded_tx_ready(rdy_s), .serdes_tx_data(ser_s),
      .idle_inserted(idle_s), .tx_bad_block(bad_s));

   baser_tx_gearbox_64 #(.SCRAMBLER_DISABLE(1'b1)) dut_b (
      .clk(clk), .rst(rst), .encoded_tx_data(data), .encoded_tx_hdr(hdr),
      .encoded_tx_valid(valid), .encoded_tx_ready(rdy_b), .serdes_tx_data(ser_b),
      .idle_inserted(idle_b), .tx_bad_block(bad_b));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d phase %0d)", nm, act, exp, cyc, phase);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Line reassembly: word bit 0 first, blocks are hdr (2 bits) then payload (64 bits).
   task automatic collect(input int i, input logic [63:0] w);
      logic [65:0] blk, exp;
      logic [63:0] pl;
      acc[i] = acc[i] | ({192'h0, w} << nb[i]);
      nb[i] += 64;
      while (nb[i] >= 66) begin
         blk    = acc[i][65:0];
         acc[i] = acc[i] >> 66;
         nb[i] -= 66;
         pl     = blk[65:2];
         if (i == 0) begin
            for (int b = 0; b < 64; b++) begin
               pl[b] = blk[b+2] ^ dsc[38] ^ dsc[57];
               dsc   = {dsc[56:0], blk[b+2]};
            end
         end
         if ((i == 0 && q_s.size() == 0) || (i == 1 && q_b.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL blk%0d: got line block %0h expected no block", i, blk);
         end else if (i == 0) begin
            exp = q_s.pop_front();
            chk("blk_scr", {pl, blk[1:0]}, exp);
         end else begin
            exp = q_b.pop_front();
            chk("blk_byp", {pl, blk[1:0]}, exp);
         end
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            acc[0] = '0; acc[1] = '0; nb[0] = 0; nb[1] = 0; dsc = '1;
         end else begin
            chk("ready", rdy_s, (cyc % 33) != 32);
            chk("ready_byp", rdy_b, (cyc % 33) != 32);
            if (cyc < 4096) begin
               chk("idle", idle_s, exp_idle[cyc]);
               chk("idle_byp", idle_b, exp_idle[cyc]);
               chk("bad", bad_s, exp_bad[cyc]);
               chk("bad_byp", bad_b, exp_bad[cyc]);
            end
            if (idle_s) idle_cnt++;
            if (cyc < 2) begin
               chk("fill", ser_s, 64'h0);
               chk("fill_byp", ser_b, 64'h0);
            end else begin
               collect(0, ser_s);
               collect(1, ser_b);
            end
            if (phase == 0 && cyc == 2) chk("byp_word2", ser_b, {p0[61:0], 2'b01});
            if (phase == 0 && cyc == 3) chk("byp_word3_lo", ser_b[1:0], p0[63:62]);
         end
      end
   end

   // One cycle of upstream activity; slot schedule comes from the 33-cycle period.
   task automatic step(input bit v, input logic [1:0] h, input logic [63:0] d, output bit took);
      logic [65:0] b;
      valid = v; hdr = h; data = d;
      took  = (cyc % 33) != 32;
      if (took) begin
         b = v ? {d, h} : {64'h000000000000001E, 2'b10};
         q_s.push_back(b);
         q_b.push_back(b);
         if (cyc + 1 < 4096) begin
            exp_idle[cyc+1] = !v;
            exp_bad[cyc+1]  = v && (h == 2'b00 || h == 2'b11);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [1:0] h, input logic [63:0] d);
      bit t = 1'b0;
      for (int k = 0; k < 3 && !t; k++) step(1'b1, h, d, t);
   endtask

   task automatic gap();
      bit t;
      step(1'b0, 2'b00, rnd64(), t);
   endtask

   task automatic clear_model();
      q_s.delete();
      q_b.delete();
      for (int k = 0; k < 4096; k++) begin
         exp_idle[k] = 1'b0;
         exp_bad[k]  = 1'b0;
      end
   endtask

   initial begin
      clear_model();
      valid = 1'b1; hdr = 2'b01; data = rnd64();
      repeat (5) begin
         @(negedge clk);
         chk("rst_ready", {rdy_s, rdy_b}, 2'b00);
         chk("rst_ser", {ser_s, ser_b}, 128'h0);
         chk("rst_flags", {idle_s, idle_b, bad_s, bad_b}, 4'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1; cyc = 0; phase = 0; mon_en = 1'b1;

      send(2'b01, p0);
      repeat (40) gap();
      send(2'b11, rnd64());
      send(2'b00, rnd64());
      chk("idle_count", idle_cnt, 39);

      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) gap();
         send(($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01, rnd64());
      end

      while ((cyc % 33) != 17) gap();
      rst = 1'b0; mon_en = 1'b0;
      #1;
      chk("midrst_ready", {rdy_s, rdy_b}, 2'b00);
      chk("midrst_ser", {ser_s, ser_b}, 128'h0);
      chk("midrst_flags", {idle_s, idle_b, bad_s, bad_b}, 4'h0);
      clear_model();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1; cyc = 0; phase = 1; mon_en = 1'b1;

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) gap();
         send(($urandom_range(0, 5) == 0) ? 2'b11 : 2'b01, rnd64());
      end
      repeat (4) gap();
      chk("drain_scr", q_s.size() <= 3, 1'b1);
      chk("drain_byp", q_b.size() <= 3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
